// File: rtl/mmio_bridge_pkg.sv
// +--------------------------------------------------------------------+
// | mmio_bridge_pkg: shared constants for the CPU data-port MMIO bridge |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package mmio_bridge_pkg;

  localparam logic [3:0] MMIO_NIB = 4'hF;

  // Word offsets taken from dataadr[7:2]
  localparam logic [5:0] OFF_LED   = 6'h00;
  localparam logic [5:0] OFF_SW    = 6'h01;
  localparam logic [5:0] OFF_TCNT  = 6'h02;
  localparam logic [5:0] OFF_TCMP  = 6'h03;
  localparam logic [5:0] OFF_TCTRL = 6'h04;
  localparam logic [5:0] OFF_TSTAT = 6'h05;

  localparam int EN_B    = 0;
  localparam int AR_B    = 1;
  localparam int IE_B    = 2;
  localparam int TCTRL_W = 3;

endpackage

`default_nettype wire

// File: rtl/mmio_timer.sv
// +--------------------------------------------------------------------+
// | mmio_timer: 32-bit compare timer with one-shot/auto-reload and IRQ  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mmio_timer
  import mmio_bridge_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tcnt_we,
  input  logic               tcmp_we,
  input  logic               tctrl_we,
  input  logic               tstat_we,
  input  logic [31:0]        wdata,
  output logic [31:0]        tcnt,
  output logic [31:0]        tcmp,
  output logic [TCTRL_W-1:0] tctrl,
  output logic               match,
  output logic               irq
);

  logic [31:0]        tcnt_q, tcnt_d;
  logic [31:0]        tcmp_q, tcmp_d;
  logic [TCTRL_W-1:0] tctrl_q, tctrl_d;
  logic               match_q, match_d;
  logic               hit;

  always_comb begin
    hit     = tctrl_q[EN_B] & (tcnt_q == tcmp_q);
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    match_d = match_q;

    if (tctrl_q[EN_B]) begin
      if (!hit) begin
        tcnt_d = tcnt_q + 32'd1;
      end else if (tctrl_q[AR_B]) begin
        tcnt_d = '0;
      end else begin
        tctrl_d[EN_B] = 1'b0;
      end
    end

    if (tstat_we && wdata[0]) begin
      match_d = 1'b0;
    end
    // A hardware match outranks a same-cycle clear so no event is lost.
    if (hit) begin
      match_d = 1'b1;
    end

    // CPU writes override the hardware update in the same cycle.
    if (tcnt_we) begin
      tcnt_d = wdata;
    end
    if (tcmp_we) begin
      tcmp_d = wdata;
    end
    if (tctrl_we) begin
      tctrl_d = wdata[TCTRL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q  <= '0;
      tcmp_q  <= 32'hFFFF_FFFF;
      tctrl_q <= '0;
      match_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
      match_q <= match_d;
    end
  end

  assign tcnt  = tcnt_q;
  assign tcmp  = tcmp_q;
  assign tctrl = tctrl_q;
  assign match = match_q;
  assign irq   = match_q & tctrl_q[IE_B];

endmodule

`default_nettype wire

// File: rtl/mmio_bridge.sv
// +--------------------------------------------------------------------+
// | mmio_bridge: routes CPU data accesses to BRAM or to LED/SW/timer    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module mmio_bridge #(
  parameter logic [3:0] MMIO_NIB = mmio_bridge_pkg::MMIO_NIB,
  parameter int          LED_W    = 16,
  parameter int          SW_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memen,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             dmem_en,
  output logic [3:0]       dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  output logic             timer_irq
);

  import mmio_bridge_pkg::*;

  logic               mmio_sel;
  logic               mmio_wr;
  logic [5:0]         off;
  logic [31:0]        mmio_rd;
  logic [LED_W-1:0]   led_q, led_d;
  logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
  logic [31:0]        tcnt, tcmp;
  logic [TCTRL_W-1:0] tctrl;
  logic               match;

  assign mmio_sel = memen & (dataadr[31:28] == MMIO_NIB);
  assign mmio_wr  = mmio_sel & memwrite;
  assign off      = dataadr[7:2];

  assign dmem_en    = memen & ~mmio_sel;
  assign dmem_we    = {4{memwrite & memen & ~mmio_sel}};
  assign dmem_addr  = dataadr;
  assign dmem_wdata = writedata;

  always_comb begin
    led_d = led_q;
    if (mmio_wr && off == OFF_LED) begin
      led_d = writedata[LED_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      led_q   <= led_d;
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  mmio_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .tcnt_we  (mmio_wr && off == OFF_TCNT),
    .tcmp_we  (mmio_wr && off == OFF_TCMP),
    .tctrl_we (mmio_wr && off == OFF_TCTRL),
    .tstat_we (mmio_wr && off == OFF_TSTAT),
    .wdata    (writedata),
    .tcnt     (tcnt),
    .tcmp     (tcmp),
    .tctrl    (tctrl),
    .match    (match),
    .irq      (timer_irq)
  );

  // Zero-latency return path lines up with the BRAM clocked on ~clk.
  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_LED:   mmio_rd = 32'(led_q);
      OFF_SW:    mmio_rd = 32'(sw_s2_q);
      OFF_TCNT:  mmio_rd = tcnt;
      OFF_TCMP:  mmio_rd = tcmp;
      OFF_TCTRL: mmio_rd = 32'(tctrl);
      OFF_TSTAT: mmio_rd = {31'd0, match};
      default:   mmio_rd = '0;
    endcase
  end

  assign readdata = mmio_sel ? mmio_rd : dmem_rdata;
  assign led      = led_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bridge.sv
// +--------------------------------------------------------------------+
// | tb_mmio_bridge: directed + random bench against a cycle model       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mmio_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memen = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic [15:0] sw = '0;
  logic [15:0] led;
  logic        timer_irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sw_drv = '0;
  logic [31:0] rd_val = '0;

  // Architectural state of the peripheral block, as seen by software
  logic [15:0] m_led, m_s1, m_s2;
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_ar, m_ie, m_match;

  mmio_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .memen      (memen),
    .memwrite   (memwrite),
    .dataadr    (dataadr),
    .writedata  (writedata),
    .readdata   (readdata),
    .dmem_en    (dmem_en),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .sw         (sw),
    .led        (led),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [5:0] off);
    case (off)
      6'd0:    return {16'd0, m_led};
      6'd1:    return {16'd0, m_s2};
      6'd2:    return m_cnt;
      6'd3:    return m_cmp;
      6'd4:    return {29'd0, m_ie, m_ar, m_en};
      6'd5:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive at negedge, check outputs, advance the model to the next posedge.
  task automatic step(input logic r, input logic en, input logic we,
                      input logic [31:0] a, input logic [31:0] wd);
    logic       sel, wr, hit;
    logic [5:0] off;
    logic [31:0] nxt_cnt;
    logic        nxt_en, nxt_match;
    @(negedge clk);
    rst = r; memen = en; memwrite = we; dataadr = a; writedata = wd;
    sw = sw_drv; dmem_rdata = rd_val;
    #1;
    sel = en && (a[31:28] == 4'hF);
    off = a[7:2];
    wr  = sel && we;
    check("readdata",   readdata, sel ? model_rd(off) : rd_val);
    check("dmem_en",    32'(dmem_en), 32'(en && !sel));
    check("dmem_we",    32'(dmem_we), (en && we && !sel) ? 32'hF : 32'h0);
    check("dmem_addr",  dmem_addr, a);
    check("dmem_wdata", dmem_wdata, wd);
    check("led",        32'(led), 32'(m_led));
    check("timer_irq",  32'(timer_irq), 32'(m_match & m_ie));

    if (r) begin
      m_led = '0; m_s1 = '0; m_s2 = '0;
      m_cnt = '0; m_cmp = 32'hFFFF_FFFF;
      m_en = 1'b0; m_ar = 1'b0; m_ie = 1'b0; m_match = 1'b0;
    end else begin
      hit       = m_en && (m_cnt == m_cmp);
      nxt_cnt   = m_cnt;
      nxt_en    = m_en;
      nxt_match = m_match;
      if (m_en) nxt_cnt = hit ? (m_ar ? 32'd0 : m_cnt) : m_cnt + 32'd1;
      if (hit && !m_ar) nxt_en = 1'b0;
      if (wr && off == 6'd5 && wd[0]) nxt_match = 1'b0;
      if (hit) nxt_match = 1'b1;
      if (wr && off == 6'd2) nxt_cnt = wd;
      if (wr && off == 6'd3) m_cmp = wd;
      if (wr && off == 6'd4) begin
        nxt_en = wd[0]; m_ar = wd[1]; m_ie = wd[2];
      end
      if (wr && off == 6'd0) m_led = wd[15:0];
      m_cnt = nxt_cnt; m_en = nxt_en; m_match = nxt_match;
      m_s2 = m_s1; m_s1 = sw_drv;
    end
  endtask

  task automatic rd(input logic [31:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 1'b1, a, d);
  endtask

  initial begin
    logic [31:0] a, wd, t;
    logic        r, en, we;

    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    rd(32'hF000_0008); check("rst_tcnt",  readdata, 32'h0);
    rd(32'hF000_000C); check("rst_tcmp",  readdata, 32'hFFFF_FFFF);
    rd(32'hF000_0010); check("rst_tctrl", readdata, 32'h0);

    // BRAM store then load
    rd_val = 32'hDEAD_BEEF;
    wr(32'h0000_0040, 32'h1234_5678);
    check("bram_we", 32'(dmem_we), 32'hF);
    check("bram_led_untouched", 32'(led), 32'h0);
    rd_val = 32'h1234_5678;
    rd(32'h0000_0040); check("bram_load", readdata, 32'h1234_5678);

    // LED store and readback
    wr(32'hF000_0000, 32'h0000_A5A5);
    check("led_st_en", 32'(dmem_en), 32'h0);
    check("led_st_we", 32'(dmem_we), 32'h0);
    rd(32'hF000_0000);
    check("led_out", 32'(led), 32'hA5A5);
    check("led_rd",  readdata, 32'h0000_A5A5);

    // Switch synchroniser latency
    sw_drv = 16'h00FF;
    rd(32'hF000_0004); check("sw_lat0", readdata, 32'h0);
    rd(32'hF000_0004); check("sw_lat1", readdata, 32'h0);
    rd(32'hF000_0004); check("sw_lat2", readdata, 32'h0000_00FF);

    // Auto-reload with interrupt
    wr(32'hF000_000C, 32'd5);
    wr(32'hF000_0010, 32'h7);
    for (int i = 0; i <= 5; i++) begin
      rd(32'hF000_0008);
      check("ar_cnt", readdata, 32'(i));
      check("ar_irq_lo", 32'(timer_irq), 32'h0);
    end
    rd(32'hF000_0008);
    check("ar_reload", readdata, 32'h0);
    check("ar_irq_hi", 32'(timer_irq), 32'h1);
    wr(32'hF000_0014, 32'h1);
    rd(32'hF000_0014);
    check("ar_w1c", readdata, 32'h0);
    check("ar_irq_clr", 32'(timer_irq), 32'h0);
    wr(32'hF000_0010, 32'h0);

    // One-shot
    wr(32'hF000_0008, 32'd0);
    wr(32'hF000_000C, 32'd3);
    wr(32'hF000_0010, 32'h1);
    for (int i = 0; i < 7; i++) rd(32'h0000_0100);
    rd(32'hF000_0008); check("os_cnt",   readdata, 32'd3);
    rd(32'hF000_0010); check("os_tctrl", readdata, 32'h0);
    rd(32'hF000_0014); check("os_match", readdata, 32'h1);
    check("os_irq", 32'(timer_irq), 32'h0);

    // Reset mid-count racing an LED write
    wr(32'hF000_000C, 32'd100);
    wr(32'hF000_0010, 32'h7);
    for (int i = 0; i < 4; i++) rd(32'h0000_0000);
    step(1'b1, 1'b1, 1'b1, 32'hF000_0000, 32'h0000_FFFF);
    rd(32'hF000_0008); check("rr_cnt",   readdata, 32'h0);
    check("rr_led", 32'(led), 32'h0);
    rd(32'hF000_000C); check("rr_tcmp",  readdata, 32'hFFFF_FFFF);
    rd(32'hF000_0010); check("rr_tctrl", readdata, 32'h0);
    rd(32'hF000_0014); check("rr_match", readdata, 32'h0);
    rd(32'hF000_0000); check("rr_ledrd", readdata, 32'h0);

    // Random traffic, including aliased MMIO addresses and unmapped offsets
    for (int n = 0; n < 3000; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        a = $urandom;
        a[31:28] = 4'hF;
        t = $urandom_range(0, 7);
        a[7:2] = t[5:0];
        a[1:0] = 2'b00;
      end else begin
        a = $urandom;
        if (a[31:28] == 4'hF) a[31:28] = 4'h0;
      end
      case ($urandom_range(0, 3))
        0:       wd = $urandom;
        1:       wd = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: wd = $urandom_range(0, 12);
      endcase
      if ($urandom_range(0, 15) == 0) sw_drv = 16'($urandom);
      rd_val = $urandom;
      step(r, en, we, a, wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
